// File: rtl/alu_bus_sequencer.sv
// ----------------------------------------------------------------------------
// alu_bus_sequencer
//
// Bus master for the ALU's shared operand interface. Takes one request
// (A, B, opcode) on a valid/ready handshake, drives the ALU bus through the
// load-A / load-B / execute sequence, captures the ALU result and returns it
// on a valid/ready response port. It is the only driver of the ALU bus.
//
// Optional feature (compile-time macro ALU_SEQ_KEEP_A_EN):
//   When defined, an accepted request with req_keep_a=1 skips LOAD_A if
//   operand A is known to be resident in the ALU. This makes the latency
//   one cycle shorter. When undefined, req_keep_a is ignored.
//
// Parameters:
//   WIDTH        operand/result width
//   OPW          opcode width
//   EXEC_CYCLES  cycles alu_outen is held before result capture (>=1)
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready     request handshake
//   req_a/req_b/req_op      operands and opcode (opcode 7 is rejected)
//   req_keep_a              reuse already-loaded A (feature macro only)
//   resp_valid/resp_ready   response handshake
//   resp_data/resp_err      ALU result (0 on error) and reject flag
//   alu_num                 shared operand bus
//   alu_enin1/alu_enin2     operand register load strobes
//   alu_op/alu_outen        opcode and output enable during execute
//   alu_result              ALU result, valid while alu_outen=1
// ----------------------------------------------------------------------------
module alu_bus_sequencer #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned OPW         = 3,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [OPW-1:0]   req_op,
    input  logic             req_keep_a,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_num,
    output logic             alu_enin1,
    output logic             alu_enin2,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_outen,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_RESP
    } state_e;

    localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [OPW-1:0] OP_REJECT = OPW'(7);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;
    logic             a_loaded_q;   // ALU operand register 1 holds a known A

    logic             req_ready_q;
    logic             resp_valid_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_err_q;
    logic [WIDTH-1:0] alu_num_q;
    logic             alu_enin1_q;
    logic             alu_enin2_q;
    logic [OPW-1:0]   alu_op_q;
    logic             alu_outen_q;

`ifndef ALU_SEQ_KEEP_A_EN
    // Keep-A port exists for pin compatibility but has no effect here.
    logic unused_keep_a;
    assign unused_keep_a = req_keep_a ^ a_loaded_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            b_q          <= '0;
            op_q         <= '0;
            a_loaded_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            alu_num_q    <= '0;
            alu_enin1_q  <= 1'b0;
            alu_enin2_q  <= 1'b0;
            alu_op_q     <= '0;
            alu_outen_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        b_q         <= req_b;
                        op_q        <= req_op;
                        if (req_op == OP_REJECT) begin
                            // Rejected: straight to response, bus untouched.
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                            a_loaded_q   <= 1'b0;
                        end
`ifdef ALU_SEQ_KEEP_A_EN
                        else if (req_keep_a && a_loaded_q) begin
                            state_q     <= S_LOAD_B;
                            alu_num_q   <= req_b;
                            alu_enin2_q <= 1'b1;
                        end
`endif
                        else begin
                            state_q     <= S_LOAD_A;
                            alu_num_q   <= req_a;
                            alu_enin1_q <= 1'b1;
                        end
                    end
                end
                S_LOAD_A: begin
                    state_q     <= S_LOAD_B;
                    alu_num_q   <= b_q;
                    alu_enin1_q <= 1'b0;
                    alu_enin2_q <= 1'b1;
                    a_loaded_q  <= 1'b1;
                end
                S_LOAD_B: begin
                    state_q     <= S_EXEC;
                    alu_num_q   <= '0;
                    alu_enin2_q <= 1'b0;
                    alu_op_q    <= op_q;
                    alu_outen_q <= 1'b1;
                    cnt_q       <= CW'(EXEC_CYCLES - 1);
                end
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        state_q      <= S_RESP;
                        alu_op_q     <= '0;
                        alu_outen_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= alu_result;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= '0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_data_q  <= '0;
                    alu_num_q    <= '0;
                    alu_enin1_q  <= 1'b0;
                    alu_enin2_q  <= 1'b0;
                    alu_op_q     <= '0;
                    alu_outen_q  <= 1'b0;
                    a_loaded_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign alu_num    = alu_num_q;
    assign alu_enin1  = alu_enin1_q;
    assign alu_enin2  = alu_enin2_q;
    assign alu_op     = alu_op_q;
    assign alu_outen  = alu_outen_q;

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_bus_sequencer
//
// Self-checking bench for alu_bus_sequencer. A small behavioural ALU sits on
// the bus (loads operand registers on the strobes, drives a result only while
// outen is high). Expected bus and response values per cycle come from a
// transaction-level model: the request's operands, the cycle offset from the
// accepting edge, and whether A is resident in the ALU.
// ----------------------------------------------------------------------------
module tb_alu_bus_sequencer;

    localparam int unsigned W    = 16;
    localparam int unsigned EXEC = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [W-1:0]  req_a, req_b;
    logic [2:0]    req_op;
    logic          req_keep_a;
    logic          resp_valid, resp_ready;
    logic [W-1:0]  resp_data;
    logic          resp_err;
    logic [W-1:0]  alu_num;
    logic          alu_enin1, alu_enin2;
    logic [2:0]    alu_op;
    logic          alu_outen;
    logic [W-1:0]  alu_result;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model state: is A resident in the ALU, and which value.
    logic          a_loaded_m = 1'b0;
    logic [W-1:0]  a_m = '0;

    always #5 clk = ~clk;

    alu_bus_sequencer #(
        .WIDTH      (W),
        .OPW        (3),
        .EXEC_CYCLES(EXEC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_keep_a (req_keep_a),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .alu_num    (alu_num),
        .alu_enin1  (alu_enin1),
        .alu_enin2  (alu_enin2),
        .alu_op     (alu_op),
        .alu_outen  (alu_outen),
        .alu_result (alu_result)
    );

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << 1;
            3'd6:    return a >> 1;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Behavioural ALU on the bus; garbage on the result bus unless enabled.
    logic [W-1:0] r1 = '0, r2 = '0;
    always @(posedge clk) begin
        if (alu_enin1) r1 <= alu_num;
        if (alu_enin2) r2 <= alu_num;
    end
    assign alu_result = alu_outen ? alu_f(r1, r2, alu_op) : 16'hBAD0;

    function automatic logic [63:0] pack(input logic rr, rv, er, input logic [W-1:0] d, n,
                                         input logic e1, e2, input logic [2:0] op, input logic oe);
        return {23'd0, rr, rv, er, d, n, e1, e2, op, oe};
    endfunction

    function automatic logic [63:0] obs_all();
        return pack(req_ready, resp_valid, resp_err, resp_data, alu_num,
                    alu_enin1, alu_enin2, alu_op, alu_outen);
    endfunction

    // Idle view excludes resp_data/resp_err, which carry no meaning once
    // resp_valid has dropped.
    function automatic logic [63:0] obs_idle();
        return pack(req_ready, resp_valid, 1'b0, 16'd0, alu_num,
                    alu_enin1, alu_enin2, alu_op, alu_outen);
    endfunction

    localparam logic [63:0] RST_VEC = {23'd0, 1'b1, 40'd0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_garbage();
        req_valid  = 1'($urandom);
        req_a      = W'($urandom);
        req_b      = W'($urandom);
        req_op     = 3'($urandom);
        req_keep_a = 1'($urandom);
    endtask

    // One transaction, entered at a negedge. delay = cycles resp_ready is held
    // low in RESP; rst_at = full-schedule cycle index at which to pulse reset
    // (0 = never).
    task automatic do_op(input logic [W-1:0] a, b, input logic [2:0] op, input logic keep,
                         input int unsigned delay, input int unsigned rst_at);
        logic          skip;
        logic [W-1:0]  exp_res;
        logic [63:0]   exp;
        int unsigned   k, kk, hold, last, waited;

        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", {63'd0, req_ready}, 64'd1);

        skip = 1'b0;
`ifdef ALU_SEQ_KEEP_A_EN
        skip = keep && a_loaded_m && (op != 3'd7);
`endif
        exp_res = alu_f(skip ? a_m : a, b, op);
        last    = (op == 3'd7) ? 1 : 3 + EXEC;
        if (op == 3'd7) a_loaded_m = 1'b0;

        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_op     = op;
        req_keep_a = keep;
        resp_ready = 1'($urandom);

        k = 1;
        hold = 0;
        for (int unsigned step = 0; step < 64; step++) begin
            @(negedge clk);
            kk = (op == 3'd7) ? last : (skip ? k + 1 : k);
            if (kk == last)
                exp = pack(1'b0, 1'b1, op == 3'd7, (op == 3'd7) ? 16'd0 : exp_res,
                           16'd0, 1'b0, 1'b0, 3'd0, 1'b0);
            else if (kk == 1) begin
                exp = pack(1'b0, 1'b0, 1'b0, 16'd0, a, 1'b1, 1'b0, 3'd0, 1'b0);
                a_m = a;
                a_loaded_m = 1'b1;
            end else if (kk == 2)
                exp = pack(1'b0, 1'b0, 1'b0, 16'd0, b, 1'b0, 1'b1, 3'd0, 1'b0);
            else
                exp = pack(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, op, 1'b1);
            check($sformatf("op%0d_c%0d_h%0d", op, kk, hold), obs_all(), exp);

            if (rst_at == kk) begin
                rst_n = 1'b0;
                req_valid = 1'b0;
                resp_ready = 1'b0;
                a_loaded_m = 1'b0;
                #1;
                check("async_reset", obs_all(), RST_VEC);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end

            if (kk == last) begin
                if (hold == delay) begin
                    resp_ready = 1'b1;
                    req_valid  = 1'b0;
                    @(negedge clk);
                    check("after_resp", obs_idle(), RST_VEC);
                    resp_ready = 1'b0;
                    return;
                end
                hold++;
                resp_ready = 1'b0;
                drive_garbage();
            end else begin
                k++;
                resp_ready = 1'($urandom);
                drive_garbage();
            end
        end
        check("op_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        resp_ready = 1'b0;
        drive_garbage();

        // Reset with inputs toggling, then release.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_hold", obs_all(), RST_VEC);
            drive_garbage();
            resp_ready = 1'($urandom);
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_release", obs_all(), RST_VEC);
        end

        // Directed first transaction.
        do_op(16'd256, 16'd255, 3'd0, 1'b0, 0, 0);

        // Opcode sweep back-to-back.
        for (int i = 0; i < 7; i++)
            do_op(W'($urandom), W'($urandom), 3'(i), 1'b0, 0, 0);

        // Rejected opcode.
        do_op(16'h1234, 16'h5678, 3'd7, 1'b0, 0, 0);

        // Response back-pressure.
        do_op(16'd1000, 16'd24, 3'd1, 1'b0, 5, 0);
        do_op(16'd0, 16'd0, 3'd7, 1'b0, 5, 0);

        // Keep-A reuse, then reset during LOAD_B clears residency.
        do_op(16'd10, 16'd3, 3'd1, 1'b0, 0, 0);
        do_op(16'd99, 16'd4, 3'd1, 1'b1, 0, 0);
        do_op(16'd5, 16'd6, 3'd2, 1'b0, 0, 2);
        do_op(16'd7, 16'd8, 3'd1, 1'b1, 0, 0);

        // Randomized traffic with idle gaps.
        for (int i = 0; i < 40; i++) begin
            req_valid = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(negedge clk);
                check("idle_gap", obs_idle(), RST_VEC);
            end
            do_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom), $urandom_range(0, 3), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
